snoop_txn_controller: RTL and testbench
=======================================

Name: snoop_txn_controller

Overview:
Sequences one coherency transaction at a time across the 4-core snoop bus: accepts core requests over valid/ready, arbitrates round-robin, broadcasts the winner, collects snoop acks and snoop results from every non-requesting core, then returns a one-cycle completion to the requester. Sits between the per-core cache controllers and the snoop broadcast fabric, replacing the fire-and-forget bus sequencing with a full request/response handshake.

Parameters:
NUM_CORES, 4, number of requesters/snoopers; power of two, 2..8
ADDR_WIDTH, 64, request address width
TIMEOUT_CYCLES, 16, max WAIT_SNOOP cycles before forced completion; range 1..255; used only with SNOOP_TIMEOUT_EN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_CORES  per-core request valid
req_ready  out  NUM_CORES  per-core accept, one-hot or zero
req_type  in  NUM_CORES x 2  per-core request type, passed through opaque
req_addr  in  NUM_CORES x ADDR_WIDTH  per-core request address
bus_valid  out  1  broadcast strobe, one cycle per transaction
bus_addr  out  ADDR_WIDTH  latched address of the current transaction
bus_type  out  2  latched type of the current transaction
bus_src  out  clog2(NUM_CORES)  requester id of the current transaction
snoop_ack  in  NUM_CORES  per-core snoop done pulse
snoop_shared  in  NUM_CORES  core holds line; sampled with its ack
snoop_dirty  in  NUM_CORES  core holds line dirty; sampled with its ack
cpl_valid  out  NUM_CORES  one-cycle completion pulse, one-hot to requester
cpl_shared  out  1  OR of sampled shared bits; valid with cpl_valid
cpl_dirty  out  1  OR of sampled dirty bits; valid with cpl_valid
cpl_timeout  out  1  completion forced by timeout; valid with cpl_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT_SNOOP, COMPLETE.
- Reset (async, any state, mid-transaction included): state=IDLE, rr_ptr=0, ack/result accumulators cleared, in-flight transaction dropped with no completion. All outputs 0; bus_addr, bus_type, bus_src also 0.
- IDLE: if any req_valid, grant the first valid core searching from rr_ptr upward with wrap. req_ready is driven combinationally to that core only in that cycle. On the handshake, latch addr, type and src; set rr_ptr=grant+1 mod NUM_CORES; go to ISSUE. With no request, stay in IDLE with req_ready=0.
- req_ready is 0 in every state except IDLE. A requester holds req_valid and its payload until it sees ready.
- ISSUE: bus_valid=1 for exactly one cycle; go to WAIT_SNOOP. Acks arriving in this cycle are counted.
- The expected ack set is all cores except bus_src. snoop_ack[bus_src] is ignored.
- Ack accumulation: a sticky ack_seen bit per core. On each ack, OR that core's shared/dirty into the accumulators. A repeated ack from the same core is ignored; its result bits are not re-sampled.
- WAIT_SNOOP: when the expected set is all seen (including acks completing in this cycle), go to COMPLETE.
- COMPLETE: for one cycle, cpl_valid[bus_src]=1 and cpl_shared/cpl_dirty/cpl_timeout are driven. Next state is IDLE, and accumulators clear.
- Latency: handshake at cycle T gives bus_valid at T+1. If all acks arrive by T+1, cpl_valid is at T+2 at the earliest. The next grant can occur at T+3.
- bus_addr, bus_type and bus_src stay stable from ISSUE through COMPLETE. Changes on req_* after the handshake have no effect.
- Acks received in IDLE or COMPLETE are ignored.

Optional Feature:
SNOOP_TIMEOUT_EN:
- Defined: an 8-bit counter clears on entry to WAIT_SNOOP and increments each WAIT_SNOOP cycle. When the count reaches TIMEOUT_CYCLES without a full ack set, go to COMPLETE with cpl_timeout=1. Results from acks already seen are reported. If the full ack set and expiry coincide, it counts as normal completion with cpl_timeout=0.
- Undefined: no counter; WAIT_SNOOP waits indefinitely; cpl_timeout tied to 0.

Test Plan:
- Core 2 requests addr 0x1000, type 1; cores 0, 1, 3 ack on the cycle after bus_valid, core 1 with shared=1 -> bus_valid one cycle with bus_src=2, bus_addr=0x1000; cpl_valid=4'b0100 with cpl_shared=1, cpl_dirty=0; rr_ptr=3.
- All 4 cores hold req_valid for 4 transactions, all acks immediate -> grants in order 0, 1, 2, 3; each core sees exactly one req_ready pulse.
- Core 0 requests; core 3 acks twice (dirty=1, then dirty=0); core 0 acks (must be ignored); cores 1 and 2 ack late -> one completion, cpl_dirty=1, COMPLETE only after core 2's ack.
- With SNOOP_TIMEOUT_EN and TIMEOUT_CYCLES=16, core 1 requests and core 2 never acks -> cpl_valid=4'b0010 with cpl_timeout=1 exactly 16 cycles after entering WAIT_SNOOP; without the macro, busy stays 1 for 100 or more cycles.
- rst_n asserted during WAIT_SNOOP -> all outputs 0 immediately; no cpl_valid after release; the next request from core 0 is granted first (rr_ptr=0).
- Core 3 raises req_valid while core 1's transaction is in WAIT_SNOOP -> req_ready[3] stays 0 until IDLE; core 3 is granted on the first IDLE cycle.

Source files
------------

// File: rtl/snoop_txn_controller.sv
// snoop_txn_controller: sequences one coherency transaction at a time on the snoop bus.
// Optional macro SNOOP_TIMEOUT_EN forces completion after TIMEOUT_CYCLES of snoop wait.
module snoop_txn_controller #(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int SW = $clog2(NUM_CORES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CORES-1:0]            req_valid,
  output logic [NUM_CORES-1:0]            req_ready,
  input  logic [2*NUM_CORES-1:0]          req_type,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr,
  output logic                            bus_valid,
  output logic [ADDR_WIDTH-1:0]           bus_addr,
  output logic [1:0]                      bus_type,
  output logic [SW-1:0]                   bus_src,
  input  logic [NUM_CORES-1:0]            snoop_ack,
  input  logic [NUM_CORES-1:0]            snoop_shared,
  input  logic [NUM_CORES-1:0]            snoop_dirty,
  output logic [NUM_CORES-1:0]            cpl_valid,
  output logic                            cpl_shared,
  output logic                            cpl_dirty,
  output logic                            cpl_timeout,
  output logic                            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CPL
  } state_t;

  localparam logic [NUM_CORES-1:0] ONE = NUM_CORES'(1);

  state_t state, state_nx;

  logic [SW-1:0]        rr_ptr;
  logic [SW-1:0]        grant;
  logic [SW-1:0]        idx;
  logic                 grant_hit;
  logic [NUM_CORES-1:0] grant_oh;
  logic [NUM_CORES-1:0] src_mask;
  logic [NUM_CORES-1:0] ack_seen;
  logic [NUM_CORES-1:0] new_ack;
  logic                 collect;
  logic                 all_seen;
  logic                 acc_shared;
  logic                 acc_dirty;

  // Round-robin search from rr_ptr; SW-bit add wraps since NUM_CORES is 2^n.
  always_comb begin
    grant_hit = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = rr_ptr + SW'(i);
      if (!grant_hit && req_valid[idx]) begin
        grant_hit = 1'b1;
        grant     = idx;
      end
    end
  end

  assign grant_oh = ONE << grant;
  assign src_mask = ONE << bus_src;
  assign collect  = (state == S_ISSUE) || (state == S_WAIT);
  assign new_ack  = snoop_ack & ~ack_seen & ~src_mask
                  & {NUM_CORES{collect}};
  assign all_seen = &(ack_seen | new_ack | src_mask);
  assign busy     = (state != S_IDLE);

`ifdef SNOOP_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_expire;
  logic       to_flag;

  assign to_expire = (to_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == S_WAIT) begin
        to_cnt  <= to_cnt + 8'd1;
        to_flag <= !all_seen && to_expire;
      end else begin
        to_cnt <= '0;
        if (state == S_IDLE) to_flag <= 1'b0;
      end
    end
  end

  assign cpl_timeout = (state == S_CPL) && to_flag;
`else
  assign cpl_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    bus_valid = 1'b0;
    cpl_valid = '0;
    unique case (state)
      S_IDLE: begin
        if (grant_hit) begin
          req_ready = rst_n ? grant_oh : '0;
          state_nx  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus_valid = 1'b1;
        state_nx  = all_seen ? S_CPL : S_WAIT;
      end
      S_WAIT: begin
        if (all_seen) state_nx = S_CPL;
`ifdef SNOOP_TIMEOUT_EN
        else if (to_expire) state_nx = S_CPL;
`endif
      end
      S_CPL: begin
        cpl_valid = src_mask;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign cpl_shared = (state == S_CPL) && acc_shared;
  assign cpl_dirty  = (state == S_CPL) && acc_dirty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      bus_addr   <= '0;
      bus_type   <= '0;
      bus_src    <= '0;
      ack_seen   <= '0;
      acc_shared <= 1'b0;
      acc_dirty  <= 1'b0;
    end else begin
      if (state == S_IDLE && grant_hit) begin
        rr_ptr   <= grant + SW'(1);
        bus_addr <= req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
        bus_type <= req_type[int'(grant)*2 +: 2];
        bus_src  <= grant;
      end
      if (state == S_CPL) begin
        ack_seen   <= '0;
        acc_shared <= 1'b0;
        acc_dirty  <= 1'b0;
      end else begin
        ack_seen   <= ack_seen | new_ack;
        acc_shared <= acc_shared | (|(new_ack & snoop_shared));
        acc_dirty  <= acc_dirty | (|(new_ack & snoop_dirty));
      end
    end
  end

endmodule

// File: tb/tb_snoop_txn_controller.sv
// tb_snoop_txn_controller: table-driven vectors plus directed multi-cycle sequences.
// Honours SNOOP_TIMEOUT_EN for the timeout scenario.
module tb_snoop_txn_controller;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [7:0]   req_type;
  logic [255:0] req_addr;
  logic         bus_valid;
  logic [63:0]  bus_addr;
  logic [1:0]   bus_type;
  logic [1:0]   bus_src;
  logic [3:0]   snoop_ack;
  logic [3:0]   snoop_shared;
  logic [3:0]   snoop_dirty;
  logic [3:0]   cpl_valid;
  logic         cpl_shared;
  logic         cpl_dirty;
  logic         cpl_timeout;
  logic         busy;

  int checks = 0;
  int failures = 0;

  logic [63:0] core_addr [4];
  logic [1:0]  core_type [4];

  typedef struct {
    logic [3:0] rv;
    logic [3:0] ack;
    logic [3:0] sh;
    logic [3:0] dt;
    logic [3:0] rdy;
    logic       bv;
    logic [1:0] src;
    logic [3:0] cpl;
    logic       csh;
    logic       cdt;
    logic       bsy;
  } vec_t;

  vec_t vt [21];

  snoop_txn_controller #(
    .NUM_CORES(4),
    .ADDR_WIDTH(64),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_type(req_type),
    .req_addr(req_addr),
    .bus_valid(bus_valid),
    .bus_addr(bus_addr),
    .bus_type(bus_type),
    .bus_src(bus_src),
    .snoop_ack(snoop_ack),
    .snoop_shared(snoop_shared),
    .snoop_dirty(snoop_dirty),
    .cpl_valid(cpl_valid),
    .cpl_shared(cpl_shared),
    .cpl_dirty(cpl_dirty),
    .cpl_timeout(cpl_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] rv, input logic [3:0] ack,
                     input logic [3:0] sh, input logic [3:0] dt);
    @(negedge clk);
    req_valid    = rv;
    snoop_ack    = ack;
    snoop_shared = sh;
    snoop_dirty  = dt;
    #1;
  endtask

  task automatic load_addr();
    for (int i = 0; i < 4; i++) begin
      req_addr[i*64 +: 64] = core_addr[i];
      req_type[i*2 +: 2]   = core_type[i];
    end
  endtask

  initial begin
    int cnt;
    core_addr[0] = 64'hA000; core_type[0] = 2'd0;
    core_addr[1] = 64'hB000; core_type[1] = 2'd2;
    core_addr[2] = 64'h1000; core_type[2] = 2'd1;
    core_addr[3] = 64'hD000; core_type[3] = 2'd3;

    //         rv       ack      sh       dt       rdy     bv src cpl   csh cdt bsy
    vt[0]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 0, 4'b0000, 0, 0, 0};
    vt[1]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 2, 4'b0000, 0, 0, 1};
    vt[2]  = '{4'b0000, 4'b1011, 4'b0010, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 1};
    vt[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0100, 1, 0, 1};
    vt[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0};
    vt[5]  = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 0, 4'b0000, 0, 0, 0};
    vt[6]  = '{4'b0001, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 1, 3, 4'b0000, 0, 0, 1};
    vt[7]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b1000, 0, 0, 1};
    vt[8]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0, 4'b0000, 0, 0, 0};
    vt[9]  = '{4'b1111, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 1};
    vt[10] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0001, 0, 0, 1};
    vt[11] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 0, 4'b0000, 0, 0, 0};
    vt[12] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 0, 1};
    vt[13] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0010, 0, 0, 1};
    vt[14] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 0, 4'b0000, 0, 0, 0};
    vt[15] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 2, 4'b0000, 0, 0, 1};
    vt[16] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0100, 0, 0, 1};
    vt[17] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 0, 4'b0000, 0, 0, 0};
    vt[18] = '{4'b1111, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 1, 3, 4'b0000, 0, 0, 1};
    vt[19] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b1000, 0, 1, 1};
    vt[20] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0};

    req_valid = '0; snoop_ack = '0; snoop_shared = '0; snoop_dirty = '0;
    load_addr();

    // reset state
    @(negedge clk); #1;
    chk("rst0_ctl", {busy, bus_valid, cpl_valid, req_ready, cpl_shared,
                     cpl_dirty, cpl_timeout, bus_src, bus_type}, 64'd0);
    chk("rst0_addr", bus_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table: basic txn, rr_ptr=3 follow-up, four-way fairness
    for (int i = 0; i < 21; i++) begin
      cyc(vt[i].rv, vt[i].ack, vt[i].sh, vt[i].dt);
      chk($sformatf("v%0d_rdy", i), req_ready, vt[i].rdy);
      chk($sformatf("v%0d_bv", i), bus_valid, vt[i].bv);
      chk($sformatf("v%0d_cpl", i), cpl_valid, vt[i].cpl);
      chk($sformatf("v%0d_csh", i), cpl_shared, vt[i].csh);
      chk($sformatf("v%0d_cdt", i), cpl_dirty, vt[i].cdt);
      chk($sformatf("v%0d_cto", i), cpl_timeout, 1'b0);
      chk($sformatf("v%0d_busy", i), busy, vt[i].bsy);
      if (vt[i].bv) begin
        chk($sformatf("v%0d_src", i), bus_src, vt[i].src);
        chk($sformatf("v%0d_addr", i), bus_addr, core_addr[vt[i].src]);
        chk($sformatf("v%0d_type", i), bus_type, core_type[vt[i].src]);
      end
    end

    // repeated ack, requester ack, late acks
    cyc(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    chk("dup_rdy", req_ready, 4'b0001);
    cyc(4'b0000, 4'b1000, 4'b0000, 4'b1000);
    chk("dup_bv", bus_valid, 1'b1);
    chk("dup_addr", bus_addr, 64'hA000);
    req_addr[63:0] = 64'hFFFF;
    cyc(4'b0000, 4'b1001, 4'b0000, 4'b0000);
    chk("dup_busy", busy, 1'b1);
    cyc(4'b0000, 4'b0010, 4'b0000, 4'b0000);
    chk("dup_cpl_a", cpl_valid, 4'b0000);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("dup_cpl_b", cpl_valid, 4'b0000);
    chk("dup_addr_hold", bus_addr, 64'hA000);
    cyc(4'b0000, 4'b0100, 4'b0000, 4'b0000);
    chk("dup_cpl_c", cpl_valid, 4'b0000);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("dup_cpl", cpl_valid, 4'b0001);
    chk("dup_dirty", cpl_dirty, 1'b1);
    chk("dup_shared", cpl_shared, 1'b0);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("dup_idle", {busy, cpl_valid}, 5'd0);
    load_addr();

    // core 1 request, core 2 never acks
    cyc(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    chk("to_rdy", req_ready, 4'b0010);
    cyc(4'b0000, 4'b1001, 4'b0001, 4'b0000);
    chk("to_bv", {bus_valid, bus_src}, {1'b1, 2'd1});
`ifdef SNOOP_TIMEOUT_EN
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
      if (cpl_valid != 4'b0000) cnt++;
    end
    chk("to_early", cnt, 0);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("to_cpl", cpl_valid, 4'b0010);
    chk("to_flag", cpl_timeout, 1'b1);
    chk("to_shared", cpl_shared, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("to_idle", busy, 1'b0);
    cyc(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    chk("r_rdy", req_ready, 4'b0100);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
`else
    cnt = 0;
    for (int k = 0; k < 120; k++) begin
      cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
      if (!busy || cpl_valid != 4'b0000) cnt++;
    end
    chk("hang_busy", cnt, 0);
`endif

    // async reset in WAIT_SNOOP
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {busy, bus_valid, cpl_valid, req_ready, cpl_shared,
                        cpl_dirty, cpl_timeout, bus_src, bus_type}, 64'd0);
    chk("mid_rst_addr", bus_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0000, 4'b1111, 4'b1111, 4'b1111);
      if (busy || cpl_valid != 4'b0000) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);
    cyc(4'b1001, 4'b0000, 4'b0000, 4'b0000);
    chk("post_rst_rr", req_ready, 4'b0001);
    cyc(4'b0000, 4'b1110, 4'b0000, 4'b0000);
    chk("post_rst_bv", {bus_valid, bus_src}, {1'b1, 2'd0});
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("post_rst_cpl", {cpl_valid, cpl_shared, cpl_dirty}, {4'b0001, 2'b00});
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // core 3 requests while core 1 is waiting on snoops
    cyc(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    chk("blk_rdy1", req_ready, 4'b0010);
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(4'b1000, 4'b0000, 4'b0000, 4'b0000);
      if (req_ready != 4'b0000) cnt++;
    end
    chk("blk_wait_rdy", cnt, 0);
    cyc(4'b1000, 4'b1101, 4'b0000, 4'b0000);
    chk("blk_last_rdy", req_ready, 4'b0000);
    cyc(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    chk("blk_cpl", {cpl_valid, req_ready}, {4'b0010, 4'b0000});
    cyc(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    chk("blk_rdy3", req_ready, 4'b1000);
    cyc(4'b0000, 4'b0111, 4'b0000, 4'b0000);
    chk("blk_bv3", {bus_valid, bus_src}, {1'b1, 2'd3});
    cyc(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("blk_cpl3", cpl_valid, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
